wb_pipe_stage: RTL

//  Parametrised MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/wb_pipe_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready comes from registered state only, so WB back-pressure never reaches MEM combinationally.

module wb_lane_out #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          vld,
  input  logic          wreg,
  input  logic [AW-1:0] wd,
  input  logic [DW-1:0] wdata,
  output logic          wreg_qual,
  output logic [AW-1:0] wd_qual,
  output logic [DW-1:0] wdata_qual
);
  // r0 writes are dropped here so WB never has to special-case them
  assign wreg_qual  = vld & wreg & (wd != '0);
  assign wd_qual    = vld ? wd    : '0;
  assign wdata_qual = vld ? wdata : '0;
endmodule

module wb_pipe_stage #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NLANE   = 1,
  parameter bit HILO_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NLANE*AW-1:0] in_wd,
  input  logic [NLANE-1:0]    in_wreg,
  input  logic [NLANE*DW-1:0] in_wdata,
  input  logic                in_whilo,
  input  logic [DW-1:0]       in_hi,
  input  logic [DW-1:0]       in_lo,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NLANE*AW-1:0] out_wd,
  output logic [NLANE-1:0]    out_wreg,
  output logic [NLANE*DW-1:0] out_wdata,
  output logic                out_whilo,
  output logic [DW-1:0]       out_hi,
  output logic [DW-1:0]       out_lo
);

  typedef struct packed {
    logic [NLANE-1:0][AW-1:0] wd;
    logic [NLANE-1:0]         wreg;
    logic [NLANE-1:0][DW-1:0] wdata;
    logic                     whilo;
    logic [DW-1:0]            hi;
    logic [DW-1:0]            lo;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;
  entry_t head, skid, head_nxt, skid_nxt, in_ent;
  logic   accept, pop;

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  // HI/LO are zeroed at capture when disabled, so the output path needs no extra gating
  always_comb begin
    in_ent       = '0;
    in_ent.wd    = in_wd;
    in_ent.wreg  = in_wreg;
    in_ent.wdata = in_wdata;
    in_ent.whilo = HILO_EN ? in_whilo : 1'b0;
    in_ent.hi    = HILO_EN ? in_hi    : '0;
    in_ent.lo    = HILO_EN ? in_lo    : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE:     if (accept & ~pop) state_nxt = FULL;
               else if (pop & ~accept) state_nxt = EMPTY;
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_comb begin
    head_nxt = head;
    skid_nxt = skid;
    if (!flush) begin
      case (state)
        EMPTY:   if (accept) head_nxt = in_ent;
        ONE:     if (accept & pop) head_nxt = in_ent;
                 else if (accept) skid_nxt = in_ent;
        FULL:    if (pop) head_nxt = skid;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = ~rst & (state != FULL);
    out_valid = (state != EMPTY);
    out_whilo = out_valid & head.whilo;
    out_hi    = out_valid ? head.hi : '0;
    out_lo    = out_valid ? head.lo : '0;
  end

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    wb_lane_out #(.DW(DW), .AW(AW)) u_lane (
      .vld        (out_valid),
      .wreg       (head.wreg[i]),
      .wd         (head.wd[i]),
      .wdata      (head.wdata[i]),
      .wreg_qual  (out_wreg[i]),
      .wd_qual    (out_wd[i*AW +: AW]),
      .wdata_qual (out_wdata[i*DW +: DW])
    );
  end

endmodule
